// File: rtl/shrimp_regfile_dumper.sv
// Debug reader for the shrimp register file: walks an address range through one
// read port and streams (address, value) beats over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; rf_r_addr holds its last value
// FETCH | rf_r_addr stable, capture combinational read data at the edge
// HOLD  | beat presented on dump_*, waiting for dump_ready
module shrimp_regfile_dumper #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_r_addr,
  input  logic [DATA_W-1:0] rf_r_val,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   last_q, last_n;
  logic [ADDR_W-1:0]   addr_n;
  logic                valid_n;
  logic [ADDR_W-1:0]   daddr_n;
  logic [DATA_W-1:0]   data_n;
  logic                dlast_n;
  logic                done_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_q     <= '0;
      rf_r_addr  <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      last_q     <= last_n;
      rf_r_addr  <= addr_n;
      dump_valid <= valid_n;
      dump_addr  <= daddr_n;
      dump_data  <= data_n;
      dump_last  <= dlast_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last_q;
    addr_n  = rf_r_addr;
    valid_n = dump_valid;
    daddr_n = dump_addr;
    data_n  = dump_data;
    dlast_n = dump_last;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          last_n  = last_addr;
          addr_n  = first_addr;
          state_n = FETCH;
        end
      end
      FETCH: begin
        // A write landing on this same edge is not seen: the pre-write value is taken.
        data_n  = rf_r_val;
        daddr_n = rf_r_addr;
        dlast_n = (rf_r_addr == last_q);
        valid_n = 1'b1;
        state_n = HOLD;
      end
      HOLD: begin
        if (dump_ready) begin
          valid_n = 1'b0;
          if (dump_last) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            addr_n  = rf_r_addr + 1'b1;
            state_n = FETCH;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_shrimp_regfile_dumper.sv
// Bench for shrimp_regfile_dumper: a register-file model feeds the read port, a
// scoreboard queue holds expected beats and a negedge monitor checks each accepted one.
module tb_shrimp_regfile_dumper;

  logic        clock = 1'b0;
  logic        reset, start, dump_ready;
  logic [3:0]  first_addr, last_addr, rf_r_addr, dump_addr;
  logic [15:0] rf_r_val, dump_data;
  logic        dump_valid, dump_last, busy, done;

  logic [15:0] rf [16];
  logic [15:0] shadow [16];
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
    logic        l;
  } beat_t;
  beat_t exp_q [$];

  typedef struct {
    logic [3:0] f;
    logic [3:0] l;
    bit         rr;
    int         beats;
  } vec_t;
  vec_t vt [6];

  int total = 0, bad = 0, done_cnt = 0, beat_cnt = 0;
  bit mon_en = 0;

  always #5 clock = ~clock;
  always @(posedge clock) if (wr_en) rf[wr_addr] <= wr_data;
  assign rf_r_val = rf[rf_r_addr];

  shrimp_regfile_dumper dut (
    .clock(clock), .reset(reset), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .rf_r_addr(rf_r_addr), .rf_r_val(rf_r_val),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_last(dump_last),
    .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin : mon
    beat_t e;
    if (mon_en) begin
      if (done) done_cnt++;
      if (dump_valid && dump_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got addr %0h, no beat expected", dump_addr);
        end else begin
          e = exp_q.pop_front();
          check("beat_addr", dump_addr, e.a);
          check("beat_data", dump_data, e.d);
          check("beat_last", dump_last, e.l);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] v);
    wr_en = 1'b1; wr_addr = a; wr_data = v;
    tick();
    wr_en = 1'b0;
    shadow[a] = v;
  endtask

  task automatic push_range(input logic [3:0] f, input logic [3:0] l);
    logic [3:0] a;
    int n;
    n = int'(4'(l - f)) + 1;
    a = f;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{a: a, d: shadow[a], l: (a == l)});
      a = a + 4'd1;
    end
  endtask

  task automatic do_start(input logic [3:0] f, input logic [3:0] l);
    first_addr = f; last_addr = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit rr);
    int d0, i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < 400) begin
      dump_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      i++;
    end
    dump_ready = 1'b1;
    if (i >= 400) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done after %0d cycles want done", i);
    end
    repeat (3) tick();
    check("done_once", done_cnt - d0, 1);
    check("queue_drained", exp_q.size(), 0);
    check("busy_after", busy, 0);
  endtask

  task automatic wait_valid();
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clock);
      if (dump_valid) break;
    end
    check("valid_seen", dump_valid, 1);
  endtask

  initial begin
    int d0, b0;
    vt[0] = '{4'd0,  4'd15, 1'b0, 16};
    vt[1] = '{4'd3,  4'd3,  1'b1, 1};
    vt[2] = '{4'd14, 4'd0,  1'b0, 3};
    vt[3] = '{4'd8,  4'd7,  1'b1, 16};
    vt[4] = '{4'd15, 4'd2,  1'b1, 4};
    vt[5] = '{4'd6,  4'd9,  1'b0, 4};

    reset = 1'b1; start = 1'b1; dump_ready = 1'b1; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; first_addr = 4'd7; last_addr = 4'd9;
    for (int i = 0; i < 16; i++) wr(4'(i), 16'(i * 16'h0111 + 16'h0005));
    start = 1'b0;
    @(negedge clock);
    check("rst_rf_r_addr", rf_r_addr, 0);
    check("rst_valid", dump_valid, 0);
    check("rst_addr", dump_addr, 0);
    check("rst_data", dump_data, 0);
    check("rst_last", dump_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick();
    reset = 1'b0;
    mon_en = 1;

    // Basic 0..1 dump with cycle-exact timing.
    wr(4'd0, 16'd120);
    wr(4'd1, 16'd7);
    push_range(4'd0, 4'd1);
    d0 = done_cnt;
    do_start(4'd0, 4'd1);
    @(negedge clock);
    check("t1_fetch_busy", busy, 1);
    check("t1_fetch_valid", dump_valid, 0);
    tick(); @(negedge clock);
    check("t1_b0_valid", dump_valid, 1);
    check("t1_b0_addr", dump_addr, 0);
    check("t1_b0_data", dump_data, 120);
    check("t1_b0_last", dump_last, 0);
    tick(); @(negedge clock);
    check("t1_gap_valid", dump_valid, 0);
    tick(); @(negedge clock);
    check("t1_b1_valid", dump_valid, 1);
    check("t1_b1_data", dump_data, 7);
    check("t1_b1_last", dump_last, 1);
    check("t1_b1_done", done, 0);
    tick(); @(negedge clock);
    check("t1_done", done, 1);
    check("t1_done_busy", busy, 0);
    check("t1_done_valid", dump_valid, 0);
    tick(); @(negedge clock);
    check("t1_done_pulse", done, 0);
    check("t1_rf_hold", rf_r_addr, 1);
    check("t1_done_cnt", done_cnt - d0, 1);
    check("t1_queue", exp_q.size(), 0);
    tick();

    // Table-driven ranges, including wrap and full dumps.
    wr(4'd14, 16'hAAAA);
    wr(4'd15, 16'hBBBB);
    wr(4'd0,  16'hCCCC);
    for (int k = 0; k < 6; k++) begin
      b0 = beat_cnt;
      push_range(vt[k].f, vt[k].l);
      do_start(vt[k].f, vt[k].l);
      wait_idle(vt[k].rr);
      check($sformatf("vec%0d_beats", k), beat_cnt - b0, vt[k].beats);
    end

    // Back-pressure: hold a single beat for 6 cycles.
    wr(4'd5, 16'h1234);
    dump_ready = 1'b0;
    push_range(4'd5, 4'd5);
    do_start(4'd5, 4'd5);
    wait_valid();
    for (int i = 0; i < 6; i++) begin
      check("bp_valid", dump_valid, 1);
      check("bp_data", dump_data, 16'h1234);
      check("bp_addr", dump_addr, 5);
      check("bp_done", done, 0);
      @(negedge clock);
    end
    b0 = beat_cnt;
    tick();
    wait_idle(1'b0);
    check("bp_beats", beat_cnt - b0, 1);

    // Write to the address being fetched, on the capture edge.
    wr(4'd3, 16'h0001);
    exp_q.push_back('{a: 4'd3, d: 16'h0001, l: 1'b1});
    do_start(4'd3, 4'd3);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hFFFF;
    tick();
    wr_en = 1'b0;
    shadow[3] = 16'hFFFF;
    wait_idle(1'b0);
    push_range(4'd3, 4'd3);
    do_start(4'd3, 4'd3);
    wait_idle(1'b0);

    // Start pulse while busy is ignored.
    b0 = beat_cnt;
    push_range(4'd0, 4'd1);
    do_start(4'd0, 4'd1);
    first_addr = 4'd9; last_addr = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(1'b0);
    check("busy_start_beats", beat_cnt - b0, 2);
    check("busy_start_rf", rf_r_addr, 1);

    // Reset while a beat is held.
    dump_ready = 1'b0;
    d0 = done_cnt;
    do_start(4'd0, 4'd1);
    wait_valid();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_valid", dump_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rf", rf_r_addr, 0);
    check("mid_rst_data", dump_data, 0);
    dump_ready = 1'b1;
    repeat (4) tick();
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_idle", busy, 0);
    push_range(4'd0, 4'd1);
    do_start(4'd0, 4'd1);
    wait_idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
